// File: rtl/multi_freq_divider.sv
// Multi-channel programmable frequency divider: each channel toggles its square-wave
// output every half-period clocks and pulses tick on every toggle.
module multi_freq_divider #(
    parameter int          CHANNELS    = 4,
    parameter int          WIDTH       = 32,
    parameter int unsigned DEFAULT_DIV = 2500,
    localparam int         LCW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] enable,
    input  logic                load,
    input  logic [LCW-1:0]      load_ch,
    input  logic [WIDTH-1:0]    load_value,
    input  logic                sync_clear,
    output logic [CHANNELS-1:0] clock_div,
    output logic [CHANNELS-1:0] tick
);

    localparam logic [WIDTH-1:0] DEF_HALF = WIDTH'(DEFAULT_DIV);

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
            logic [WIDTH-1:0] count_reg;
            logic [WIDTH-1:0] half_reg;
            logic [WIDTH-1:0] pend_reg;
            logic             pend_v_reg;
            logic             div_reg;
            logic             tick_reg;
            logic [WIDTH-1:0] last_count;
            logic             hit;
            logic             expire;

            // A half-period of 0 is treated as 1, so the last count value is 0 in both cases.
            assign last_count = (half_reg == '0) ? '0 : half_reg - WIDTH'(1);
            // Out-of-range channel indices never match any channel and are dropped here.
            assign hit        = load && (load_ch == LCW'(gi));
            // ">=" also catches a counter left beyond a freshly shrunk half-period.
            assign expire     = enable[gi] && (count_reg >= last_count);

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    count_reg  <= '0;
                    half_reg   <= DEF_HALF;
                    pend_reg   <= '0;
                    pend_v_reg <= 1'b0;
                    div_reg    <= 1'b0;
                    tick_reg   <= 1'b0;
                end else begin
                    tick_reg <= 1'b0;
                    if (sync_clear) begin
                        count_reg <= '0;
                        div_reg   <= 1'b0;
                        if (pend_v_reg) half_reg <= pend_reg;
                    end else if (enable[gi]) begin
                        if (expire) begin
                            count_reg <= '0;
                            div_reg   <= ~div_reg;
                            tick_reg  <= 1'b1;
                            if (pend_v_reg) half_reg <= pend_reg;
                        end else begin
                            count_reg <= count_reg + WIDTH'(1);
                        end
                    end else if (pend_v_reg) begin
                        half_reg <= pend_reg;
                    end

                    // A new load is staged after any application of the old staged value.
                    if (hit) begin
                        pend_reg   <= load_value;
                        pend_v_reg <= 1'b1;
                    end else if (sync_clear || !enable[gi] || expire) begin
                        pend_v_reg <= 1'b0;
                    end
                end
            end

            assign clock_div[gi] = div_reg;
            assign tick[gi]      = tick_reg;
        end
    endgenerate

endmodule

// File: tb/tb_multi_freq_divider.sv
// Bench for multi_freq_divider: table vectors, hand-written corner sequences and
// randomized traffic checked against a per-channel behavioural model.
module tb_multi_freq_divider;

    localparam int CH  = 3;
    localparam int W   = 16;
    localparam int DEF = 4;
    localparam int LCW = 2;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic [CH-1:0] enable = '0;
    logic          load = 1'b0;
    logic [LCW-1:0] load_ch = '0;
    logic [W-1:0]  load_value = '0;
    logic          sync_clear = 1'b0;
    logic [CH-1:0] clock_div;
    logic [CH-1:0] tick;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    multi_freq_divider #(.CHANNELS(CH), .WIDTH(W), .DEFAULT_DIV(DEF)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .enable     (enable),
        .load       (load),
        .load_ch    (load_ch),
        .load_value (load_value),
        .sync_clear (sync_clear),
        .clock_div  (clock_div),
        .tick       (tick)
    );

    // Behavioural model: clocks elapsed in the current half-period, active and staged half-period.
    int m_half[CH];
    int m_pend[CH];
    int m_elapsed[CH];
    bit m_pv[CH];
    bit m_div[CH];
    bit m_tick[CH];

    function automatic int eff_half(int h);
        return (h == 0) ? 1 : h;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_half[c] = DEF; m_pend[c] = 0; m_elapsed[c] = 0;
            m_pv[c] = 0; m_div[c] = 0; m_tick[c] = 0;
        end
    endtask

    task automatic model_step();
        for (int c = 0; c < CH; c++) begin
            bit hit;
            hit = load && (int'(load_ch) == c);
            m_tick[c] = 0;
            if (sync_clear) begin
                m_elapsed[c] = 0;
                m_div[c] = 0;
                if (m_pv[c]) m_half[c] = m_pend[c];
                m_pv[c] = 0;
            end else if (!enable[c]) begin
                if (m_pv[c]) m_half[c] = m_pend[c];
                m_pv[c] = 0;
            end else if (m_elapsed[c] + 1 >= eff_half(m_half[c])) begin
                m_div[c] = !m_div[c];
                m_tick[c] = 1;
                m_elapsed[c] = 0;
                if (m_pv[c]) m_half[c] = m_pend[c];
                m_pv[c] = 0;
            end else begin
                m_elapsed[c]++;
            end
            if (hit) begin
                m_pend[c] = int'(load_value);
                m_pv[c] = 1;
            end
        end
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cyc(string tag);
        logic [CH-1:0] ed, et;
        model_step();
        for (int c = 0; c < CH; c++) begin
            ed[c] = m_div[c];
            et[c] = m_tick[c];
        end
        @(posedge clock);
        #1;
        check({tag, " model div"}, 32'(clock_div), 32'(ed));
        check({tag, " model tick"}, 32'(tick), 32'(et));
    endtask

    task automatic wait_tick(int ch, int maxc, output int n);
        n = -1;
        for (int i = 1; i <= maxc; i++) begin
            cyc("wait");
            if (tick[ch]) begin
                n = i;
                return;
            end
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        enable = '0; load = 1'b0; load_ch = '0; load_value = '0; sync_clear = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check("reset div", 32'(clock_div), 32'd0);
        check("reset tick", 32'(tick), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic [CH-1:0]  en;
        logic           ld;
        logic [LCW-1:0] ch;
        logic [W-1:0]   val;
        logic           clr;
        logic [CH-1:0]  ediv;
        logic [CH-1:0]  etick;
    } vec_t;

    vec_t tbl[17];

    initial begin
        int n;

        tbl[0]  = '{3'b111, 1'b0, 2'd0, 16'd0, 1'b0, 3'b000, 3'b000};
        tbl[1]  = '{3'b111, 1'b0, 2'd0, 16'd0, 1'b0, 3'b000, 3'b000};
        tbl[2]  = '{3'b111, 1'b0, 2'd0, 16'd0, 1'b0, 3'b000, 3'b000};
        tbl[3]  = '{3'b111, 1'b0, 2'd0, 16'd0, 1'b0, 3'b111, 3'b111};
        tbl[4]  = '{3'b111, 1'b1, 2'd1, 16'd2, 1'b0, 3'b111, 3'b000};
        tbl[5]  = '{3'b111, 1'b0, 2'd0, 16'd0, 1'b0, 3'b111, 3'b000};
        tbl[6]  = '{3'b111, 1'b0, 2'd0, 16'd0, 1'b0, 3'b111, 3'b000};
        tbl[7]  = '{3'b111, 1'b0, 2'd0, 16'd0, 1'b0, 3'b000, 3'b111};
        tbl[8]  = '{3'b111, 1'b0, 2'd0, 16'd0, 1'b0, 3'b000, 3'b000};
        tbl[9]  = '{3'b111, 1'b0, 2'd0, 16'd0, 1'b0, 3'b010, 3'b010};
        tbl[10] = '{3'b111, 1'b1, 2'd3, 16'd1, 1'b0, 3'b010, 3'b000};
        tbl[11] = '{3'b111, 1'b0, 2'd0, 16'd0, 1'b0, 3'b101, 3'b111};
        tbl[12] = '{3'b111, 1'b0, 2'd0, 16'd0, 1'b1, 3'b000, 3'b000};
        tbl[13] = '{3'b111, 1'b0, 2'd0, 16'd0, 1'b0, 3'b000, 3'b000};
        tbl[14] = '{3'b111, 1'b0, 2'd0, 16'd0, 1'b0, 3'b010, 3'b010};
        tbl[15] = '{3'b111, 1'b0, 2'd0, 16'd0, 1'b0, 3'b010, 3'b000};
        tbl[16] = '{3'b111, 1'b0, 2'd0, 16'd0, 1'b0, 3'b101, 3'b111};

        // Table: default toggling, mid-period load, invalid channel, sync_clear realignment.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            enable = tbl[i].en; load = tbl[i].ld; load_ch = tbl[i].ch;
            load_value = tbl[i].val; sync_clear = tbl[i].clr;
            cyc("table");
            check($sformatf("table[%0d] div", i), 32'(clock_div), 32'(tbl[i].ediv));
            check($sformatf("table[%0d] tick", i), 32'(tick), 32'(tbl[i].etick));
            $display("vec %0d en=%b ld=%b ch=%0d val=%0d clr=%b -> div=%b tick=%b",
                     i, tbl[i].en, tbl[i].ld, tbl[i].ch, tbl[i].val, tbl[i].clr, clock_div, tick);
        end
        load = 1'b0; sync_clear = 1'b0;

        // Mid-period load of 10 on ch1: current half-period keeps 4, then 10.
        do_reset();
        enable = '1;
        cyc("seqA"); cyc("seqA");
        load = 1'b1; load_ch = 2'd1; load_value = 16'd10;
        cyc("seqA");
        load = 1'b0;
        wait_tick(1, 20, n); check("seqA first toggle", 32'(n), 32'd1);
        wait_tick(1, 20, n); check("seqA second gap", 32'(n), 32'd10);
        wait_tick(1, 20, n); check("seqA third gap", 32'(n), 32'd10);
        $display("seqA mid-period load done");

        // Load 0 on ch2: toggles every cycle with tick held high.
        do_reset();
        enable = '1;
        load = 1'b1; load_ch = 2'd2; load_value = 16'd0;
        cyc("seqB");
        load = 1'b0;
        wait_tick(2, 10, n); check("seqB expiry", 32'(n), 32'd3);
        for (int i = 0; i < 5; i++) begin
            cyc("seqB");
            check("seqB tick high", 32'(tick[2]), 32'd1);
            check("seqB div toggle", 32'(clock_div[2]), 32'((i % 2 == 0) ? 0 : 1));
        end
        $display("seqB zero half-period done");

        // Ch0 paused at count 2 for 7 cycles.
        do_reset();
        enable = '1;
        cyc("seqC"); cyc("seqC");
        enable = 3'b110;
        for (int i = 0; i < 7; i++) begin
            cyc("seqC");
            check("seqC hold div", 32'(clock_div[0]), 32'd0);
            check("seqC hold tick", 32'(tick[0]), 32'd0);
        end
        enable = '1;
        wait_tick(0, 10, n); check("seqC resume", 32'(n), 32'd2);
        $display("seqC pause/resume done");

        // Load on the expiry cycle: applied one expiry later.
        do_reset();
        enable = '1;
        cyc("seqD"); cyc("seqD"); cyc("seqD");
        load = 1'b1; load_ch = 2'd0; load_value = 16'd6;
        cyc("seqD");
        check("seqD expiry tick", 32'(tick[0]), 32'd1);
        load = 1'b0;
        wait_tick(0, 20, n); check("seqD old half", 32'(n), 32'd4);
        wait_tick(0, 20, n); check("seqD new half", 32'(n), 32'd6);
        $display("seqD load-on-expiry done");

        // Asynchronous reset mid-period.
        do_reset();
        enable = '1;
        repeat (4) cyc("seqE");
        check("seqE before reset", 32'(clock_div), 32'h7);
        #1;
        reset_n = 1'b0;
        #1;
        check("seqE async div", 32'(clock_div), 32'd0);
        check("seqE async tick", 32'(tick), 32'd0);
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        wait_tick(0, 10, n); check("seqE restart", 32'(n), 32'd4);
        $display("seqE async reset done");

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            enable     = ($urandom_range(0, 3) == 0) ? CH'($urandom) : '1;
            load       = ($urandom_range(0, 3) == 0);
            load_ch    = LCW'($urandom_range(0, 3));
            load_value = W'($urandom_range(0, 6));
            sync_clear = ($urandom_range(0, 49) == 0);
            if (load)
                $display("rand %0d load ch=%0d val=%0d en=%b clr=%b", i, load_ch, load_value, enable, sync_clear);
            cyc("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
